// File: rtl/min_list_pkg.sv
// min_list_pkg
//   Shared types and helpers for the min-list collector.
//   - state_t  : collector FSM encoding (IDLE / COLLECT / DRAIN)
//   - widths   : LLR_W, Q_W, IDXA_W, IDXI_W and the packed entry width ENTRY_W
//   - entry_t  : one survivor {llr, q, index_a, index_i}
//   - pack_entry / unpack_entry : convert between fields and the flat RAM word
package min_list_pkg;

  localparam int LLR_W   = 6;
  localparam int Q_W     = 7;
  localparam int IDXA_W  = 6;
  localparam int IDXI_W  = 6;
  localparam int ENTRY_W = LLR_W + Q_W + IDXA_W + IDXI_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

  typedef struct packed {
    logic [LLR_W-1:0]  llr;
    logic [Q_W-1:0]    q;
    logic [IDXA_W-1:0] index_a;
    logic [IDXI_W-1:0] index_i;
  } entry_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [LLR_W-1:0]  llr,
    input logic [Q_W-1:0]    q,
    input logic [IDXA_W-1:0] index_a,
    input logic [IDXI_W-1:0] index_i
  );
    return {llr, q, index_a, index_i};
  endfunction

  function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] word);
    entry_t e;
    e = entry_t'(word);
    return e;
  endfunction

endpackage

// File: rtl/min_list_ram.sv
// min_list_ram
//   Survivor storage: DEPTH x WIDTH register file, one synchronous write
//   port and one asynchronous read port. Storage is not reset; the
//   collector never reads an entry it has not written in the current frame.
// Ports
//   clk      in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  read data (combinational)
module min_list_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/min_list_collector.sv
// min_list_collector
//   Takes the ascending-LLR candidate stream from the min sorter, keeps the
//   first occurrence of each GF symbol (later ones have larger LLR and are
//   discarded), buffers up to DEPTH survivors and replays them in arrival
//   order on a valid/ready port toward the check-node update.
//
//   Optional feature macro: MIN_LIST_NORM_EN
//     defined   : out_llr is normalised to the first survivor's LLR
//                 (stored - base, clamped at 0), so the first output reads 0
//     undefined : out_llr is the stored LLR, no base register
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   candidate beat handshake (beats while in_ready=0 are dropped)
//   in_last               final candidate of the frame
//   in_llr, in_q, in_index_a, in_index_i   candidate fields
//   out_valid / out_ready survivor replay handshake
//   out_llr, out_q, out_index_a, out_index_i, out_last   survivor fields
//   out_count             survivors in the current frame
//   err_trunc             sticky: more than DEPTH unique symbols this frame
//   err_drop              sticky: beat offered while in_ready was low
//
// state   | meaning
// IDLE    | waiting for first beat of a frame, dedup bitmap clear
// COLLECT | accepting beats, deduplicating and storing survivors
// DRAIN   | replaying survivors, input side blocked
module min_list_collector
  import min_list_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [LLR_W-1:0]  in_llr,
  input  logic [Q_W-1:0]    in_q,
  input  logic [IDXA_W-1:0] in_index_a,
  input  logic [IDXI_W-1:0] in_index_i,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LLR_W-1:0]  out_llr,
  output logic [Q_W-1:0]    out_q,
  output logic [IDXA_W-1:0] out_index_a,
  output logic [IDXI_W-1:0] out_index_i,
  output logic              out_last,
  output logic [CNT_W-1:0]  out_count,
  output logic              err_trunc,
  output logic              err_drop
);

  localparam int AW = $clog2(DEPTH);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [AW-1:0]      rd_ptr;
  logic [2**Q_W-1:0]  bitmap;

  logic               take_beat;
  logic               sym_seen;
  logic               room;
  logic               accept;
  logic [CNT_W-1:0]   count_nxt;
  logic [ENTRY_W-1:0] wr_data;
  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  entry_t             rd_entry;
  entry_t             head_entry;
  logic               drain_fire;
  logic [LLR_W-1:0]   head_llr_out;
  logic [LLR_W-1:0]   next_llr_out;

`ifdef MIN_LIST_NORM_EN
  logic [LLR_W-1:0]   base;
  logic [LLR_W-1:0]   base_eff;

  function automatic logic [LLR_W-1:0] norm_llr(
    input logic [LLR_W-1:0] llr,
    input logic [LLR_W-1:0] ref_llr
  );
    return (llr >= ref_llr) ? (llr - ref_llr) : '0;
  endfunction
`endif

  always_comb begin
    take_beat  = in_valid && (state != ST_DRAIN);
    sym_seen   = bitmap[in_q];
    room       = (count < CNT_W'(DEPTH));
    accept     = take_beat && !sym_seen && room;
    count_nxt  = accept ? (count + CNT_W'(1)) : count;
    wr_data    = pack_entry(in_llr, in_q, in_index_a, in_index_i);
    // Outside DRAIN the read port looks at entry 0 so the first survivor can
    // be registered on the in_last beat; inside DRAIN it looks one ahead.
    rd_addr    = (state == ST_DRAIN) ? (rd_ptr + AW'(1)) : '0;
    rd_entry   = unpack_entry(rd_data);
    // A single-beat frame writes entry 0 in the same cycle it must be
    // presented, so bypass the RAM when nothing is stored yet.
    head_entry = (count == '0) ? unpack_entry(wr_data) : rd_entry;
    drain_fire = (state == ST_DRAIN) && out_valid && out_ready;
  end

`ifdef MIN_LIST_NORM_EN
  assign base_eff     = (count == '0) ? in_llr : base;
  assign head_llr_out = norm_llr(head_entry.llr, base_eff);
  assign next_llr_out = norm_llr(rd_entry.llr, base);
`else
  assign head_llr_out = head_entry.llr;
  assign next_llr_out = rd_entry.llr;
`endif

  min_list_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (count[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      count       <= '0;
      rd_ptr      <= '0;
      bitmap      <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_llr     <= '0;
      out_q       <= '0;
      out_index_a <= '0;
      out_index_i <= '0;
      err_trunc   <= 1'b0;
      err_drop    <= 1'b0;
`ifdef MIN_LIST_NORM_EN
      base        <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (in_valid) begin
            // Flags from the previous frame stay visible until this frame starts.
            if (state == ST_IDLE) begin
              err_trunc <= 1'b0;
              err_drop  <= 1'b0;
            end
            if (accept) begin
              bitmap[in_q] <= 1'b1;
              count        <= count_nxt;
`ifdef MIN_LIST_NORM_EN
              if (count == '0) begin
                base <= in_llr;
              end
`endif
            end else if (!sym_seen) begin
              err_trunc <= 1'b1;
            end
            if (in_last) begin
              state       <= ST_DRAIN;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
              out_last    <= (count_nxt == CNT_W'(1));
              out_llr     <= head_llr_out;
              out_q       <= head_entry.q;
              out_index_a <= head_entry.index_a;
              out_index_i <= head_entry.index_i;
            end else begin
              state <= ST_COLLECT;
            end
          end
        end

        ST_DRAIN: begin
          if (in_valid) begin
            err_drop <= 1'b1;
          end
          if (drain_fire) begin
            if (out_last) begin
              state     <= ST_IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              bitmap    <= '0;
              count     <= '0;
              rd_ptr    <= '0;
            end else begin
              rd_ptr      <= rd_ptr + AW'(1);
              out_last    <= ((CNT_W'(rd_ptr) + CNT_W'(2)) == count);
              out_llr     <= next_llr_out;
              out_q       <= rd_entry.q;
              out_index_a <= rd_entry.index_a;
              out_index_i <= rd_entry.index_i;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_count = count;

endmodule

// File: tb/tb_min_list_collector.sv
module tb_min_list_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_last;
  logic [5:0] in_llr;
  logic [6:0] in_q;
  logic [5:0] in_index_a, in_index_i;
  logic       in_ready;
  logic       out_valid, out_ready;
  logic [5:0] out_llr;
  logic [6:0] out_q;
  logic [5:0] out_index_a, out_index_i;
  logic       out_last;
  logic [4:0] out_count;
  logic       err_trunc, err_drop;

  int checks   = 0;
  int failures = 0;

  // model of the current frame
  int         m_cnt;
  bit         m_seen [128];
  logic [5:0] m_llr  [16];
  logic [6:0] m_q    [16];
  logic [5:0] m_a    [16];
  logic [5:0] m_i    [16];
  bit         m_trunc;

  always #5 clk = ~clk;

  min_list_collector dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_llr      (in_llr),
    .in_q        (in_q),
    .in_index_a  (in_index_a),
    .in_index_i  (in_index_i),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_llr     (out_llr),
    .out_q       (out_q),
    .out_index_a (out_index_a),
    .out_index_i (out_index_i),
    .out_last    (out_last),
    .out_count   (out_count),
    .err_trunc   (err_trunc),
    .err_drop    (err_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_llr(input int idx);
`ifdef MIN_LIST_NORM_EN
    return (m_llr[idx] >= m_llr[0]) ? (m_llr[idx] - m_llr[0]) : 6'd0;
`else
    return m_llr[idx];
`endif
  endfunction

  task automatic model_clear();
    m_cnt   = 0;
    m_trunc = 0;
    for (int k = 0; k < 128; k++) m_seen[k] = 0;
  endtask

  // Drives one beat starting at posedge+1, leaves at the following posedge+1.
  task automatic send(input logic [6:0] q, input logic [5:0] llr,
                      input logic [5:0] a, input logic [5:0] i, input logic last);
    chk("in_ready_collect", in_ready, 1'b1);
    in_valid   = 1'b1;
    in_last    = last;
    in_q       = q;
    in_llr     = llr;
    in_index_a = a;
    in_index_i = i;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!m_seen[q]) begin
      if (m_cnt < 16) begin
        m_seen[q]    = 1;
        m_q[m_cnt]   = q;
        m_llr[m_cnt] = llr;
        m_a[m_cnt]   = a;
        m_i[m_cnt]   = i;
        m_cnt++;
      end else begin
        m_trunc = 1;
      end
    end
  endtask

  // Consumes the whole drain, checking every presented cycle against the model.
  task automatic drain(input bit stall, input bit inject_drop);
    int idx = 0;
    int cyc = 0;
    chk("drain_count", out_count, m_cnt);
    chk("drain_trunc", err_trunc, m_trunc);
    while (idx < m_cnt && cyc < 400) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject_drop && cyc == 1) begin
        in_valid = 1'b1;
        in_q     = 7'h11;
        in_llr   = 6'd0;
      end
      chk("out_valid", out_valid, 1'b1);
      chk("in_ready_drain", in_ready, 1'b0);
      chk("out_q", out_q, m_q[idx]);
      chk("out_llr", out_llr, exp_llr(idx));
      chk("out_index_a", out_index_a, m_a[idx]);
      chk("out_index_i", out_index_i, m_i[idx]);
      chk("out_last", out_last, (idx == m_cnt - 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (out_ready) idx++;
      cyc++;
    end
    if (cyc >= 400) chk("drain_timeout", 0, 1);
    out_ready = 1'b0;
    chk("post_drain_valid", out_valid, 1'b0);
    chk("post_drain_ready", in_ready, 1'b1);
    chk("post_drain_count", out_count, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 0; in_last = 0; in_llr = 0; in_q = 0;
    in_index_a = 0; in_index_i = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_llr", out_llr, 0);
    chk("rst_count", out_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err", {err_trunc, err_drop}, 2'b00);
    reset = 1'b0;
    @(posedge clk); #1;

    // T1: duplicate q=3 dropped
    model_clear();
    send(7'd3, 6'd1, 6'd1, 6'd11, 0);
    send(7'd5, 6'd2, 6'd2, 6'd12, 0);
    send(7'd3, 6'd2, 6'd3, 6'd13, 0);
    send(7'd9, 6'd4, 6'd4, 6'd14, 1);
    chk("t1_count", out_count, 3);
    chk("t1_first_q", out_q, 7'd3);
    chk("t1_third_q_model", m_q[2], 7'd9);
    drain(0, 0);
    chk("t1_err_drop", err_drop, 0);

    // T2: 20 unique symbols, 16 kept, truncation flagged
    model_clear();
    for (int k = 0; k < 20; k++)
      send(7'(10 + k), 6'(k / 2), 6'(k), 6'(63 - k), (k == 19));
    chk("t2_count", out_count, 16);
    chk("t2_trunc", err_trunc, 1);
    drain(0, 0);

    // T3: single-beat frame, also clears the sticky truncation flag
    model_clear();
    send(7'h7F, 6'd7, 6'd5, 6'd6, 1);
    chk("t3_trunc_cleared", err_trunc, 0);
    chk("t3_last", out_last, 1);
`ifdef MIN_LIST_NORM_EN
    chk("t3_llr", out_llr, 6'd0);
`else
    chk("t3_llr", out_llr, 6'd7);
`endif
    drain(0, 0);

    // T4: random stalls, dropped beat during DRAIN
    model_clear();
    for (int k = 0; k < 6; k++)
      send(7'(40 + 3 * k), 6'(5 + k), 6'(20 + k), 6'(30 + k), (k == 5));
    drain(1, 1);
    chk("t4_err_drop", err_drop, 1);

    // T5: reset mid-COLLECT
    model_clear();
    for (int k = 0; k < 5; k++)
      send(7'(60 + k), 6'(k), 6'(k), 6'(k), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_count", out_count, 0);
    chk("t5_err_drop_cleared", err_drop, 0);
    model_clear();
    send(7'd60, 6'd2, 6'd7, 6'd8, 0);
    send(7'd61, 6'd3, 6'd9, 6'd10, 1);
    chk("t5_new_count", out_count, 2);
    drain(0, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_no_extra", out_valid, 0);
    end

    // T6: same symbol set twice, second frame must not be deduped
    for (int f = 0; f < 2; f++) begin
      model_clear();
      send(7'd1, 6'd1, 6'd1, 6'd1, 0);
      send(7'd2, 6'd1, 6'd2, 6'd2, 0);
      send(7'd3, 6'd3, 6'd3, 6'd3, 1);
      chk("t6_count", out_count, 3);
      drain(0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
